// File: rtl/bank_resp_arb_pkg.sv
// Shared widths, record types and helpers for the bank response arbiter.
// Used by the interface, the top, the round-robin sub-block and the bench.
package bank_resp_arb_pkg;

  localparam int DEF_NUM_BANKS = 4;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ID_W      = 32;
  localparam int COUNT_W       = 32;
  localparam int CYCLE_W       = 64;

  // Bank index width; a single bank still needs a one-bit index.
  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_BANK_W = bank_w(DEF_NUM_BANKS);

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_ID_W-1:0]   id;
  } resp_t;

  typedef struct packed {
    resp_t                 resp;
    logic [DEF_BANK_W-1:0] bank;
    logic [CYCLE_W-1:0]    cycle;
  } out_resp_t;

endpackage

// File: rtl/bank_resp_arb_if.sv
// Per-bank response inputs plus the single forwarded response channel.
// master = bank schedulers and downstream consumer, slave = the arbiter.
interface bank_resp_arb_if #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 32
);
  import bank_resp_arb_pkg::*;
  localparam int BANK_W = bank_w(NUM_BANKS);

  logic [NUM_BANKS-1:0]             in_valid;
  logic [NUM_BANKS-1:0]             in_ready;
  logic [NUM_BANKS-1:0][ADDR_W-1:0] in_addr;
  logic [NUM_BANKS-1:0][DATA_W-1:0] in_data;
  logic [NUM_BANKS-1:0][ID_W-1:0]   in_id;

  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_addr;
  logic [DATA_W-1:0]  out_data;
  logic [ID_W-1:0]    out_id;
  logic [BANK_W-1:0]  out_bank;
  logic [CYCLE_W-1:0] out_cycle;

  modport master (
    output in_valid, in_addr, in_data, in_id, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_id, out_bank, out_cycle
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_id, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_id, out_bank, out_cycle
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req at or after ptr, wrapping.
// Emits a one-hot grant and its encoded index (index is 0 when nothing is granted).
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = W'(k);
      end
    end
  end

endmodule

// File: rtl/bank_response_arbiter.sv
// Round-robin merge of per-bank responses into one registered output stage with
// bank/cycle tagging and stats counters. Optional starvation watchdog: BANK_RESP_ARB_STARVE_WDOG_EN.
module bank_response_arbiter
  import bank_resp_arb_pkg::*;
#(
  parameter int NUM_BANKS    = DEF_NUM_BANKS,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ID_W         = DEF_ID_W,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  bank_resp_arb_if.slave                      bus,
  output logic [NUM_BANKS-1:0][COUNT_W-1:0]   bank_count,
  output logic [COUNT_W-1:0]                  total_count,
  output logic [NUM_BANKS-1:0]                starve_err
);

  localparam int BANK_W = bank_w(NUM_BANKS);

  logic                 load_en, fire, valid_q;
  logic [NUM_BANKS-1:0] req, grant;
  logic [BANK_W-1:0]    g_idx, rr_ptr, bank_q;
  logic [CYCLE_W-1:0]   cycle_q, out_cycle_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    data_q;
  logic [ID_W-1:0]      id_q;
  logic [COUNT_W-1:0]   total_q;

  // Only arbitrate when the output stage can take a response this cycle.
  assign load_en = !valid_q || bus.out_ready;
  assign req     = load_en ? bus.in_valid : '0;

  rr_arbiter #(.N(NUM_BANKS)) u_rr (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (g_idx)
  );

  assign fire         = |grant;
  assign bus.in_ready = grant;

  always_ff @(posedge clk) begin
    if (!reset) cycle_q <= '0;
    else        cycle_q <= cycle_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      id_q        <= '0;
      bank_q      <= '0;
      out_cycle_q <= '0;
    end else if (load_en) begin
      valid_q <= fire;
      if (fire) begin
        addr_q      <= bus.in_addr[g_idx];
        data_q      <= bus.in_data[g_idx];
        id_q        <= bus.in_id[g_idx];
        bank_q      <= g_idx;
        out_cycle_q <= cycle_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)    rr_ptr <= '0;
    else if (fire) rr_ptr <= (g_idx == BANK_W'(NUM_BANKS - 1)) ? '0 : g_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset)                      total_q <= '0;
    else if (fire && total_q != '1)  total_q <= total_q + 1'b1;
  end

  assign bus.out_valid = valid_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;
  assign bus.out_bank  = bank_q;
  assign bus.out_cycle = out_cycle_q;
  assign total_count   = total_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [COUNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (!reset)                       cnt_q <= '0;
      else if (grant[b] && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end

    assign bank_count[b] = cnt_q;

`ifdef BANK_RESP_ARB_STARVE_WDOG_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    logic [WAIT_W-1:0] wait_q, wait_nxt;
    logic              err_q;

    always_comb begin
      wait_nxt = wait_q;
      if (!bus.in_valid[b] || grant[b])            wait_nxt = '0;
      else if (wait_q != WAIT_W'(STARVE_LIMIT))    wait_nxt = wait_q + 1'b1;
    end

    // Sticky until reset, even after the bank is finally served.
    always_ff @(posedge clk) begin
      if (!reset) begin
        wait_q <= '0;
        err_q  <= 1'b0;
      end else begin
        wait_q <= wait_nxt;
        if (wait_nxt == WAIT_W'(STARVE_LIMIT)) err_q <= 1'b1;
      end
    end

    assign starve_err[b] = err_q;
`else
    assign starve_err[b] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bank_response_arbiter.sv
// Randomised scoreboard bench for bank_response_arbiter against a queue/array
// reference model of the round-robin, counter and watchdog rules.
module tb_bank_response_arbiter;
  import bank_resp_arb_pkg::*;

  localparam int NB    = 4;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NB-1:0][COUNT_W-1:0] bank_count;
  logic [COUNT_W-1:0]         total_count;
  logic [NB-1:0]              starve_err;

  bank_resp_arb_if #(.NUM_BANKS(NB)) bus();

  bank_response_arbiter #(.NUM_BANKS(NB), .STARVE_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .bank_count  (bank_count),
    .total_count (total_count),
    .starve_err  (starve_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference global cycle counter.
  logic [CYCLE_W-1:0] cyc = '0;
  always @(posedge clk) cyc <= !reset ? '0 : cyc + 1'b1;

  out_resp_t sb[$];

  // Requester and reference-model state.
  bit              pend[NB];
  resp_t           pl[NB];
  bit              m_full;
  int              m_ptr;
  longint unsigned m_cnt[NB];
  longint unsigned m_tot;
  int              m_wait[NB];
  bit              m_err[NB];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pops expected responses as they leave, checks stall stability.
  logic  stall_prev = 1'b0;
  resp_t stall_pl;
  logic [DEF_BANK_W-1:0] stall_bank;
  always @(negedge clk) begin
    out_resp_t e;
    if (reset && bus.out_valid) begin
      if (stall_prev) begin
        chk("hold_addr", bus.out_addr, stall_pl.addr);
        chk("hold_data", bus.out_data, stall_pl.data);
        chk("hold_id",   bus.out_id,   stall_pl.id);
        chk("hold_bank", bus.out_bank, stall_bank);
      end
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else if (bus.out_ready) begin
        e = sb.pop_front();
        chk("out_addr",  bus.out_addr,  e.resp.addr);
        chk("out_data",  bus.out_data,  e.resp.data);
        chk("out_id",    bus.out_id,    e.resp.id);
        chk("out_bank",  bus.out_bank,  e.bank);
        chk("out_cycle", bus.out_cycle, e.cycle);
      end
    end
    stall_prev <= reset && bus.out_valid && !bus.out_ready;
    stall_pl   <= '{addr: bus.out_addr, data: bus.out_data, id: bus.out_id};
    stall_bank <= bus.out_bank;
  end

  // One clock cycle of stimulus + model; entered and left at posedge+2.
  task automatic step(input logic [NB-1:0] new_req, input bit rdy, input bit rst_n);
    logic [NB-1:0] exp_rdy, exp_err;
    int g;
    for (int b = 0; b < NB; b++) begin
      if (!rst_n) pend[b] = 1'b0;
      else if (!pend[b] && new_req[b]) begin
        pend[b] = 1'b1;
        pl[b]   = '{addr: $urandom(), data: $urandom(), id: $urandom()};
      end
    end
    reset         = rst_n;
    bus.out_ready = rdy;
    for (int b = 0; b < NB; b++) begin
      bus.in_valid[b] = pend[b];
      bus.in_addr[b]  = pl[b].addr;
      bus.in_data[b]  = pl[b].data;
      bus.in_id[b]    = pl[b].id;
    end
    #2;
    g = -1;
    exp_rdy = '0;
    if (rst_n && (!m_full || rdy))
      for (int i = 0; i < NB; i++)
        if (g < 0 && pend[(m_ptr + i) % NB]) g = (m_ptr + i) % NB;
    if (g >= 0) exp_rdy[g] = 1'b1;
    if (rst_n) begin
      for (int b = 0; b < NB; b++) exp_err[b] = m_err[b];
      chk("in_ready",    bus.in_ready, exp_rdy);
      chk("total_count", total_count,  m_tot);
      chk("starve_err",  starve_err,   exp_err);
      for (int b = 0; b < NB; b++) chk($sformatf("bank_count%0d", b), bank_count[b], m_cnt[b]);
    end
    if (!rst_n) begin
      m_full = 1'b0; m_ptr = 0; m_tot = 0;
      for (int b = 0; b < NB; b++) begin m_cnt[b] = 0; m_wait[b] = 0; m_err[b] = 1'b0; end
      sb.delete();
    end else begin
`ifdef BANK_RESP_ARB_STARVE_WDOG_EN
      for (int b = 0; b < NB; b++) begin
        m_wait[b] = (pend[b] && b != g) ? ((m_wait[b] < LIMIT) ? m_wait[b] + 1 : LIMIT) : 0;
        if (m_wait[b] == LIMIT) m_err[b] = 1'b1;
      end
`endif
      if (g >= 0) begin
        sb.push_back('{resp: pl[g], bank: DEF_BANK_W'(g), cycle: cyc});
        pend[g] = 1'b0;
        m_ptr   = (g + 1) % NB;
        if (m_cnt[g] != 64'hFFFF_FFFF) m_cnt[g]++;
        if (m_tot != 64'hFFFF_FFFF) m_tot++;
        m_full = 1'b1;
      end else if (rdy) begin
        m_full = 1'b0;
      end
    end
    @(posedge clk);
    #2;
  endtask

  longint unsigned saved[NB];

  initial begin
    bus.in_valid = '0; bus.in_addr = '0; bus.in_data = '0; bus.in_id = '0;
    bus.out_ready = 1'b0;
    @(posedge clk); #2;
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);

    // Reset state.
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_addr",  bus.out_addr,  0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_out_id",    bus.out_id,    0);
    chk("rst_out_bank",  bus.out_bank,  0);
    chk("rst_out_cycle", bus.out_cycle, 0);
    chk("rst_total",     total_count,   0);

    // Single bank: bank 2 fires in cycle 5.
    repeat (5) step('0, 1'b1, 1'b1);
    pend[2] = 1'b1;
    pl[2]   = '{addr: 32'h100, data: 32'hAB, id: 32'd7};
    step('0, 1'b1, 1'b1);
    chk("single_valid", bus.out_valid,  1);
    chk("single_bank",  bus.out_bank,   2);
    chk("single_id",    bus.out_id,     7);
    chk("single_addr",  bus.out_addr,   32'h100);
    chk("single_cycle", bus.out_cycle,  5);
    chk("single_cnt2",  bank_count[2],  1);
    chk("single_total", total_count,    1);

    // Fairness: everyone valid, 8 grants -> 2 each.
    for (int b = 0; b < NB; b++) saved[b] = bank_count[b];
    repeat (8) step('1, 1'b1, 1'b1);
    for (int b = 0; b < NB; b++) chk($sformatf("fair_cnt%0d", b), bank_count[b], saved[b] + 2);

    // Backpressure then release with no bubble.
    repeat (3) step('1, 1'b0, 1'b1);
    step('1, 1'b1, 1'b1);
    chk("nobubble_valid", bus.out_valid, 1);

    // Watchdog: stall output while bank 3 waits.
    step('1, 1'b1, 1'b1);
    repeat (6) step(4'b1000, 1'b0, 1'b1);
`ifdef BANK_RESP_ARB_STARVE_WDOG_EN
    chk("wdog_set", starve_err[3], 1);
`else
    chk("wdog_off", starve_err, 0);
`endif
    repeat (6) step(4'b1000, 1'b1, 1'b1);
`ifdef BANK_RESP_ARB_STARVE_WDOG_EN
    chk("wdog_sticky", starve_err[3], 1);
`else
    chk("wdog_off2", starve_err, 0);
`endif

    // Reset while a response is held and counters are nonzero.
    step('1, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_total", total_count,   0);
    chk("midrst_err",   starve_err,    0);
    step('1, 1'b1, 1'b1);
    chk("midrst_first_bank", bus.out_bank, 0);

    // Saturation of bank 1 counter.
    repeat (3) step('0, 1'b1, 1'b1);
    force dut.g_bank[1].cnt_q = 32'hFFFF_FFFF;
    m_cnt[1] = 64'hFFFF_FFFF;
    step('0, 1'b1, 1'b1);
    release dut.g_bank[1].cnt_q;
    step(4'b0010, 1'b1, 1'b1);
    chk("sat_cnt1", bank_count[1], 32'hFFFF_FFFF);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++)
      step(NB'($urandom()), ($urandom_range(0, 3) != 0), 1'b1);

    repeat (6) step('0, 1'b1, 1'b1);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
